// File: rtl/nco_quarter_wave_if.sv
// nco_quarter_wave_if
// Bundles the control inputs and sample outputs of nco_quarter_wave.
// clk and rst stay outside the bundle as plain module ports.
//
// Signals:
//   freq_word    phase increment captured on freq_load
//   freq_load    load strobe for the increment register
//   phase_offset static phase offset added to every sample
//   bpsk_bit     1 rotates the sample phase by half a turn
//   phase_sync   restarts the accumulator at phase 0
//   enable       requests one sample and advances the accumulator
//   sin_out      signed sine sample
//   cos_out      signed cosine sample (only when NCO_COS_EN is defined)
//   valid        sin_out/cos_out carry a new sample this cycle
//
// Modports: master drives the controls (stimulus side), slave is the NCO.
// Optional feature macro: NCO_COS_EN (adds cos_out).
`timescale 1ns/1ps

interface nco_quarter_wave_if #(
    parameter int PHASE_WIDTH = 32,
    parameter int DATA_WIDTH  = 12
);
    logic [PHASE_WIDTH-1:0]       freq_word;
    logic                         freq_load;
    logic [PHASE_WIDTH-1:0]       phase_offset;
    logic                         bpsk_bit;
    logic                         phase_sync;
    logic                         enable;
    logic signed [DATA_WIDTH-1:0] sin_out;
`ifdef NCO_COS_EN
    logic signed [DATA_WIDTH-1:0] cos_out;
`endif
    logic                         valid;

`ifdef NCO_COS_EN
    modport master (
        output freq_word, freq_load, phase_offset, bpsk_bit, phase_sync, enable,
        input  sin_out, cos_out, valid
    );

    modport slave (
        input  freq_word, freq_load, phase_offset, bpsk_bit, phase_sync, enable,
        output sin_out, cos_out, valid
    );
`else
    modport master (
        output freq_word, freq_load, phase_offset, bpsk_bit, phase_sync, enable,
        input  sin_out, valid
    );

    modport slave (
        input  freq_word, freq_load, phase_offset, bpsk_bit, phase_sync, enable,
        output sin_out, valid
    );
`endif

endinterface

// File: rtl/nco_quarter_wave.sv
// nco_quarter_wave
// Numerically controlled oscillator for the BPSK modulator. A phase
// accumulator drives a quarter-wave ROM whose output is unfolded by quadrant
// into a full signed sine (and optionally cosine). BPSK inversion is a half
// turn added in the phase domain. Three registered stages, latency 3.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   bus   slave modport of nco_quarter_wave_if (controls, samples, valid)
//
// Parameters:
//   PHASE_WIDTH  accumulator / frequency word width
//   ADDR_WIDTH   quarter-wave ROM address bits (N = 2^ADDR_WIDTH entries)
//   DATA_WIDTH   signed output width, amplitude 2^(DATA_WIDTH-1)-1
//
// Optional feature macro: NCO_COS_EN builds the cosine path and cos_out.
`timescale 1ns/1ps

module nco_quarter_wave #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 12
) (
    input  logic                clk,
    input  logic                rst,
    nco_quarter_wave_if.slave   bus
);

    localparam int  N         = 1 << ADDR_WIDTH;
    localparam int  MAG_WIDTH = DATA_WIDTH - 1;
    localparam int  AMPLITUDE = (1 << (DATA_WIDTH - 1)) - 1;
    localparam int  DECODE_W  = ADDR_WIDTH + 2;
    localparam int  SHIFT     = PHASE_WIDTH - DECODE_W;
    localparam real PI        = 3.14159265358979323846;

    // ROM entry k samples the quarter wave at the centre of its bin
    // (k + 0.5). That half-bin offset makes entry N-1-k the exact mirror
    // of entry k, so the unfold needs no extra N-th entry.
    function automatic logic [MAG_WIDTH-1:0] rom_entry(input int idx);
        real angle;
        real value;
        angle = PI / 2.0 * (real'(idx) + 0.5) / real'(N);
        value = real'(AMPLITUDE) * $sin(angle);
        return MAG_WIDTH'($rtoi(value + 0.5));
    endfunction

    logic [MAG_WIDTH-1:0] rom [N];

    // Table contents are fixed at elaboration; reads below become a ROM.
    for (genvar i = 0; i < N; i++) begin : g_rom
        localparam logic [MAG_WIDTH-1:0] ENTRY = rom_entry(i);
        assign rom[i] = ENTRY;
    end

    logic [PHASE_WIDTH-1:0] inc;
    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH-1:0] sample_acc;
    logic [PHASE_WIDTH-1:0] bpsk_turn;
    logic [PHASE_WIDTH-1:0] phase;
    logic [DECODE_W-1:0]    phase_top;

    logic                   s1_valid;
    logic [1:0]             s1_quad;
    logic [ADDR_WIDTH-1:0]  s1_index;
    logic [ADDR_WIDTH-1:0]  sin_addr;

    logic                   s2_valid;
    logic [1:0]             s2_quad;
    logic [MAG_WIDTH-1:0]   s2_sin_mag;
    logic [DATA_WIDTH-1:0]  sin_mag_ext;
    logic [DATA_WIDTH-1:0]  sin_next;

    logic                   valid_q;
    logic [DATA_WIDTH-1:0]  sin_q;

    // Increment register. A load only affects advances from the next cycle
    // on, so an enable in the same cycle still uses the old increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            inc <= '0;
        end else if (bus.freq_load) begin
            inc <= bus.freq_word;
        end
    end

    // Phase accumulator, modulo 2^PHASE_WIDTH. phase_sync restarts at 0;
    // if a sample is also taken that cycle it is the phase-0 sample and the
    // accumulator moves straight on to one increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (bus.phase_sync) begin
            acc <= bus.enable ? inc : '0;
        end else if (bus.enable) begin
            acc <= acc + inc;
        end
    end

    // Sample phase: accumulator (or 0 on sync) plus offset plus the BPSK
    // half turn. Only the top quadrant+address bits are kept; the rest is
    // truncated without rounding.
    always_comb begin
        sample_acc = bus.phase_sync ? '0 : acc;
        bpsk_turn  = {bus.bpsk_bit, {(PHASE_WIDTH-1){1'b0}}};
        phase      = sample_acc + bus.phase_offset + bpsk_turn;
        phase_top  = DECODE_W'(phase >> SHIFT);
    end

    // Valid shift register: a sample requested at t is presented at t+3.
    // Reset clears it so in-flight samples are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            s1_valid <= bus.enable;
            s2_valid <= s1_valid;
            valid_q  <= s2_valid;
        end
    end

    // Stage 1: capture quadrant and quarter-wave index of the sample phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_quad  <= '0;
            s1_index <= '0;
        end else if (bus.enable) begin
            s1_quad  <= phase_top[DECODE_W-1 -: 2];
            s1_index <= phase_top[ADDR_WIDTH-1:0];
        end
    end

    // Odd quadrants walk the table backwards; N-1-k is the bitwise inverse.
    always_comb begin
        sin_addr = s1_quad[0] ? ~s1_index : s1_index;
    end

    // Stage 2: ROM read plus the quadrant needed later for the sign.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_quad    <= '0;
            s2_sin_mag <= '0;
        end else if (s1_valid) begin
            s2_quad    <= s1_quad;
            s2_sin_mag <= rom[sin_addr];
        end
    end

    // Lower half of the circle (quadrants 2 and 3) is negative. The
    // magnitude never exceeds the amplitude, so negation cannot overflow.
    always_comb begin
        sin_mag_ext = {1'b0, s2_sin_mag};
        sin_next    = s2_quad[1] ? -sin_mag_ext : sin_mag_ext;
    end

    // Stage 3: output register, holds its value between samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sin_q <= '0;
        end else if (s2_valid) begin
            sin_q <= sin_next;
        end
    end

    assign bus.sin_out = sin_q;
    assign bus.valid   = valid_q;

`ifdef NCO_COS_EN
    logic [1:0]            cos_quad_s1;
    logic [ADDR_WIDTH-1:0] cos_addr;
    logic [MAG_WIDTH-1:0]  s2_cos_mag;
    logic [1:0]            cos_quad_s2;
    logic [DATA_WIDTH-1:0] cos_mag_ext;
    logic [DATA_WIDTH-1:0] cos_next;
    logic [DATA_WIDTH-1:0] cos_q;

    // Cosine is the sine unfold applied one quadrant ahead.
    always_comb begin
        cos_quad_s1 = s1_quad + 2'd1;
        cos_addr    = cos_quad_s1[0] ? ~s1_index : s1_index;
    end

    // Second ROM read port, aligned with the sine read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_cos_mag <= '0;
        end else if (s1_valid) begin
            s2_cos_mag <= rom[cos_addr];
        end
    end

    always_comb begin
        cos_quad_s2 = s2_quad + 2'd1;
        cos_mag_ext = {1'b0, s2_cos_mag};
        cos_next    = cos_quad_s2[1] ? -cos_mag_ext : cos_mag_ext;
    end

    // Cosine output register, same timing as sin_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            cos_q <= '0;
        end else if (s2_valid) begin
            cos_q <= cos_next;
        end
    end

    assign bus.cos_out = cos_q;
`endif

endmodule

// File: tb/tb_nco_quarter_wave.sv
// tb_nco_quarter_wave
// Directed scenarios followed by random stimulus. Expected samples come from
// a reference that evaluates round(A*sin) / round(A*cos) at the centre of the
// decoded phase bin, with a queue enforcing the three-cycle latency.
// Define NCO_COS_EN for both bench and design to exercise cos_out.
`timescale 1ns/1ps

module tb_nco_quarter_wave;

    localparam int  PW     = 32;
    localparam int  AW     = 8;
    localparam int  DW     = 12;
    localparam int  AMP    = 2047;
    localparam int  J_BITS = AW + 2;
    localparam real PI     = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    nco_quarter_wave_if #(.PHASE_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

    nco_quarter_wave #(
        .PHASE_WIDTH(PW),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int due;
        int sin_v;
        int cos_v;
    } sample_t;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          edge_count   = 0;
    int          hold_sin     = 0;
    int          hold_cos     = 0;
    logic [31:0] model_acc    = '0;
    logic [31:0] model_inc    = '0;
    sample_t     pending[$];
    int          captured[$];

    // Round half away from zero so positive and negative halves match.
    function automatic int round_sym(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else          return -$rtoi(-x + 0.5);
    endfunction

    // Full-circle bin index j: the top quadrant+address bits of the phase.
    function automatic real bin_angle(input logic [31:0] p);
        int j;
        j = int'(p >> (PW - J_BITS));
        return 2.0 * PI * (real'(j) + 0.5) / real'(1 << J_BITS);
    endfunction

    function automatic int ref_sin(input logic [31:0] p);
        return round_sym(real'(AMP) * $sin(bin_angle(p)));
    endfunction

    function automatic int ref_cos(input logic [31:0] p);
        return round_sym(real'(AMP) * $cos(bin_angle(p)));
    endfunction

    task automatic checkValue(input string tag, input int observed, input int expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Compare outputs after an edge against the reference queue; when no
    // sample is due, valid must be low and the outputs must hold.
    task automatic checkOutput();
        int exp_valid;
        exp_valid = 0;
        if (pending.size() > 0 && pending[0].due == edge_count) begin
            exp_valid = 1;
            hold_sin  = pending[0].sin_v;
            hold_cos  = pending[0].cos_v;
            void'(pending.pop_front());
        end
        checkValue($sformatf("valid@%0d", edge_count), int'(bus.valid), exp_valid);
        checkValue($sformatf("sin_out@%0d", edge_count), int'($signed(bus.sin_out)), hold_sin);
`ifdef NCO_COS_EN
        checkValue($sformatf("cos_out@%0d", edge_count), int'($signed(bus.cos_out)), hold_cos);
`endif
        if (bus.valid === 1'b1) captured.push_back(int'($signed(bus.sin_out)));
    endtask

    // Drive one cycle of inputs, advance the reference model across the
    // clock edge, then check outputs 1 ns after the edge.
    task automatic applyStimulus(input logic r, input logic en, input logic sync,
                                 input logic load, input logic [31:0] fw,
                                 input logic [31:0] off, input logic bpsk);
        logic [31:0] p;
        sample_t     s;
        rst              = r;
        bus.enable       = en;
        bus.phase_sync   = sync;
        bus.freq_load    = load;
        bus.freq_word    = fw;
        bus.phase_offset = off;
        bus.bpsk_bit     = bpsk;
        @(posedge clk);
        edge_count++;
        if (r) begin
            model_acc = '0;
            model_inc = '0;
            pending.delete();
            hold_sin  = 0;
            hold_cos  = 0;
        end else begin
            if (en) begin
                p       = (sync ? 32'd0 : model_acc) + off + (bpsk ? 32'h8000_0000 : 32'd0);
                s.due   = edge_count + 2;
                s.sin_v = ref_sin(p);
                s.cos_v = ref_cos(p);
                pending.push_back(s);
            end
            if (sync)    model_acc = en ? model_inc : 32'd0;
            else if (en) model_acc = model_acc + model_inc;
            if (load)    model_inc = fw;
        end
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic checkSequence(input string tag, input int expected_len, input int exp_seq[8]);
        checkValue({tag, "_count"}, captured.size(), expected_len);
        for (int i = 0; i < expected_len; i++) begin
            checkValue($sformatf("%s[%0d]", tag, i),
                       (i < captured.size()) ? captured[i] : -99999, exp_seq[i]);
        end
    endtask

    initial begin
        int quarter_seq[8];
        int bpsk_seq[8];
        int wrap_seq[8];
        int load_seq[8];
        int gap_seq[8];
        quarter_seq = '{6, 2047, -6, -2047, 6, 2047, -6, -2047};
        bpsk_seq    = '{6, 2047, 6, 2047, -6, 2047, -6, -2047};
        wrap_seq    = '{-6, 6, 6, 6, 6, 6, 0, 0};
        load_seq    = '{6, 6, 6, 6, 2047, -6, 0, 0};
        gap_seq     = '{6, 2047, -6, 0, 0, 0, 0, 0};

        // Reset held with enable and load active: outputs stay at zero.
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h4000_0000, 32'd0, 1'b0);
        // First enable after release: valid exactly three edges later.
        captured.delete();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        idle(3);
        checkValue("reset_first_sample_count", captured.size(), 1);

        // Quarter-turn step.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'd0, 1'b0);
        captured.delete();
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1'b1, (i == 0), 1'b0, 32'd0, 32'd0, 1'b0);
        idle(3);
        checkSequence("quarter", 8, quarter_seq);

        // BPSK flip on samples 2..4.
        captured.delete();
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1'b1, (i == 0), 1'b0, 32'd0, 32'd0, (i >= 2 && i <= 4));
        idle(3);
        checkSequence("bpsk", 8, bpsk_seq);

        // Wrap with half-turn offset.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        captured.delete();
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b1, (i == 0), 1'b0, 32'd0, 32'h8000_0000, 1'b0);
        idle(3);
        checkSequence("wrap", 6, wrap_seq);

        // freq_load while enabled at inc=0.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
        captured.delete();
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b1, (i == 0), (i == 2), 32'h4000_0000, 32'd0, 1'b0);
        idle(3);
        checkSequence("load_en", 6, load_seq);

        // Gapped enable: outputs hold in the gaps.
        captured.delete();
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, (i % 2 == 0), (i == 0), 1'b0, 32'd0, 32'd0, 1'b0);
        idle(3);
        checkSequence("gapped", 3, gap_seq);

        // Reset in the middle of the pipeline drops in-flight samples.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        idle(4);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 7) == 0),
                          $urandom, $urandom,
                          1'($urandom_range(0, 1)));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
